// File: rtl/rbus_pkg.sv
// Shared definitions for the branch-side bus: data word type, credit width and FSM encodings.
// Latency: none (package only).
// Backpressure: n/a.
package rbus_pkg;

    // Width of one bus data word.
    localparam int RBUS_W = 32;

    // Credit return width toward the slice switch box (single-frame and back-to-back credit).
    localparam int RBUS_RDY_W = 2;

    typedef logic [RBUS_W-1:0] rbus_word_t;

    // Write-side frame FSM encodings.
    localparam logic [1:0] WR_IDLE    = 2'd0;
    localparam logic [1:0] WR_RECV    = 2'd1;
    localparam logic [1:0] WR_DISCARD = 2'd2;

endpackage

// File: rtl/rbus_sdp_ram.sv
// Simple dual-port frame storage: one write port, one read port with a registered read.
// Latency: read data appears one clock after i_re; write is visible to reads on the following cycle.
// Backpressure: none; o_rdata holds its value while i_re is low, so it can act as a holding stage.
module rbus_sdp_ram
    import rbus_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = $bits(rbus_word_t)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; output is held when no read is requested.
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/rsbus_branch_r2d_buffer.sv
// Store-and-forward frame buffer between a slice switch box branch and its device; drops malformed frames.
// Latency: last input word accepted at edge T -> o_stb at edge T+2; frames stream out back-to-back.
// Backpressure: 2-bit registered slot credit upstream; output words held stable while o_ack is low.
module rsbus_branch_r2d_buffer
    import rbus_pkg::*;
#(
    parameter int FRAME_LEN    = 8,
    parameter int DEPTH_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stb,
    input  logic                  i_sof,
    input  rbus_word_t            i_bus,
    output logic [RBUS_RDY_W-1:0] i_rdy,
    output logic                  o_stb,
    output logic                  o_sof,
    output rbus_word_t            o_bus,
    input  logic                  o_ack,
    output logic                  ff_err
);

    localparam int TOTAL  = FRAME_LEN * DEPTH_FRAMES;
    localparam int ADDR_W = $clog2(TOTAL);
    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam int SLOT_W = $clog2(DEPTH_FRAMES + 1);

    // Pointers wrap at the exact storage size, which need not be a power of two.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(TOTAL - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    // Write-side state.
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_wr_commit;
    logic [CNT_W-1:0]  r_wcnt;
    logic [CNT_W-1:0]  r_disc_cnt;
    logic              r_err;

    // Shared occupancy and credit.
    logic [SLOT_W-1:0]     r_slots_used;
    logic [SLOT_W-1:0]     r_frames_ready;
    logic [SLOT_W-1:0]     r_fetch_avail;
    logic [RBUS_RDY_W-1:0] r_i_rdy;

    // Read-side state: fetch pointer, RAM output stage, show-ahead output register.
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_fcnt;
    logic              r_p1_vld;
    logic              r_p1_sof;
    logic              r_p1_last;
    logic              r_o_stb;
    logic              r_o_sof;
    logic              r_o_last;
    rbus_word_t        r_o_bus;

    // Write-side combinational decode.
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [CNT_W-1:0]  w_wcnt_nxt;
    logic [CNT_W-1:0]  w_disc_nxt;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_waddr;
    logic              w_we;
    logic              w_reserve;
    logic              w_drop_rel;
    logic              w_commit;
    logic              w_err_set;
    logic              w_room;
    logic              w_start;

    // Read-side combinational decode.
    logic              w_pop;
    logic              w_last_pop;
    logic              w_o_load;
    logic              w_rd_issue;
    logic              w_fetch_last;
    rbus_word_t        w_rdata;
    logic [SLOT_W-1:0] w_used_nxt;
    logic [SLOT_W-1:0] w_free_nxt;

    // Frame write FSM: accepts, rolls back or discards incoming words.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_wcnt_nxt   = r_wcnt;
        w_disc_nxt   = r_disc_cnt;
        w_base       = r_wr_ptr;
        w_waddr      = r_wr_ptr;
        w_we         = 1'b0;
        w_reserve    = 1'b0;
        w_drop_rel   = 1'b0;
        w_commit     = 1'b0;
        w_err_set    = 1'b0;
        w_start      = 1'b0;
        w_room       = (r_slots_used != SLOT_W'(DEPTH_FRAMES));
        if (i_stb) begin
            case (r_state)
                WR_RECV: begin
                    if (i_sof) begin
                        // Truncated frame: give its slot back and restart from the commit point.
                        w_drop_rel = 1'b1;
                        w_err_set  = 1'b1;
                        w_base     = r_wr_commit;
                        w_room     = 1'b1;
                        w_start    = 1'b1;
                    end else begin
                        w_we         = 1'b1;
                        w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
                        if (r_wcnt == CNT_W'(FRAME_LEN - 1)) begin
                            w_commit    = 1'b1;
                            w_state_nxt = WR_IDLE;
                            w_wcnt_nxt  = '0;
                        end else begin
                            w_wcnt_nxt = r_wcnt + CNT_W'(1);
                        end
                    end
                end
                WR_DISCARD: begin
                    if (i_sof) begin
                        w_start = 1'b1;
                    end else if (r_disc_cnt == CNT_W'(FRAME_LEN - 2)) begin
                        w_state_nxt = WR_IDLE;
                        w_disc_nxt  = '0;
                    end else begin
                        w_disc_nxt = r_disc_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (i_sof) begin
                        w_start = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            endcase
            if (w_start) begin
                if (w_room) begin
                    w_reserve    = 1'b1;
                    w_we         = 1'b1;
                    w_waddr      = w_base;
                    w_wr_ptr_nxt = ptr_inc(w_base);
                    w_wcnt_nxt   = CNT_W'(1);
                    w_state_nxt  = WR_RECV;
                end else begin
                    w_err_set    = 1'b1;
                    w_wr_ptr_nxt = w_base;
                    w_disc_nxt   = '0;
                    w_state_nxt  = WR_DISCARD;
                end
            end
        end
    end

    // Read pipeline control: fetch into the RAM stage, move into the output register on pop or empty.
    always_comb begin
        w_pop        = r_o_stb & o_ack;
        w_last_pop   = w_pop & r_o_last;
        w_o_load     = r_p1_vld & (~r_o_stb | w_pop);
        w_rd_issue   = (r_fetch_avail != '0) & (r_frames_ready != '0) & (~r_p1_vld | w_o_load);
        w_fetch_last = (r_fcnt == CNT_W'(FRAME_LEN - 1));
        w_used_nxt   = r_slots_used + SLOT_W'(w_reserve) - SLOT_W'(w_drop_rel) - SLOT_W'(w_last_pop);
        w_free_nxt   = SLOT_W'(DEPTH_FRAMES) - w_used_nxt;
    end

    // Write FSM, pointers and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WR_IDLE;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_wcnt      <= '0;
            r_disc_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_disc_cnt <= w_disc_nxt;
            if (w_commit) begin
                r_wr_commit <= w_wr_ptr_nxt;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Slot, frame and fetch counters plus the registered upstream credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slots_used   <= '0;
            r_frames_ready <= '0;
            r_fetch_avail  <= '0;
            r_i_rdy        <= '0;
        end else begin
            r_slots_used   <= w_used_nxt;
            r_frames_ready <= r_frames_ready + SLOT_W'(w_commit) - SLOT_W'(w_last_pop);
            r_fetch_avail  <= r_fetch_avail + SLOT_W'(w_commit) - SLOT_W'(w_rd_issue & w_fetch_last);
            r_i_rdy        <= {(w_free_nxt >= SLOT_W'(2)), (w_free_nxt >= SLOT_W'(1))};
        end
    end

    // Fetch pointer and RAM-stage tags travelling alongside the registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_fcnt    <= '0;
            r_p1_vld  <= 1'b0;
            r_p1_sof  <= 1'b0;
            r_p1_last <= 1'b0;
        end else begin
            r_p1_vld <= w_rd_issue | (r_p1_vld & ~w_o_load);
            if (w_rd_issue) begin
                r_rd_ptr  <= ptr_inc(r_rd_ptr);
                r_fcnt    <= w_fetch_last ? '0 : r_fcnt + CNT_W'(1);
                r_p1_sof  <= (r_fcnt == '0);
                r_p1_last <= w_fetch_last;
            end
        end
    end

    // Show-ahead output register: holds while the device stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_stb  <= 1'b0;
            r_o_sof  <= 1'b0;
            r_o_last <= 1'b0;
            r_o_bus  <= '0;
        end else if (w_o_load) begin
            r_o_stb  <= 1'b1;
            r_o_sof  <= r_p1_sof;
            r_o_last <= r_p1_last;
            r_o_bus  <= w_rdata;
        end else if (w_pop) begin
            r_o_stb  <= 1'b0;
            r_o_sof  <= 1'b0;
            r_o_last <= 1'b0;
        end
    end

    rbus_sdp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W ($bits(rbus_word_t))
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_bus),
        .i_re    (w_rd_issue),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign i_rdy  = r_i_rdy;
    assign o_stb  = r_o_stb;
    assign o_sof  = r_o_sof;
    assign o_bus  = r_o_bus;
    assign ff_err = r_err;

endmodule
